// File: rtl/key_pkg.sv
// Shared definitions for the key conditioner: default timings, width
// helpers, the released pin level and the hold-phase state type.
package key_pkg;

    localparam int DEBOUNCE_CYC_DEF = 12;
    localparam int LONG_CYC_DEF     = 1000;
    localparam int REPEAT_CYC_DEF   = 200;

    // Counter width needed to hold the values 0..n-1 (never below one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Pin level seen while a key is not pressed.
    function automatic logic released_raw(input bit active_low);
        return active_low;
    endfunction

    // Hold-counter phase: counting to the first long press, counting
    // auto-repeat periods, or parked after a single long press.
    typedef enum logic [1:0] {
        HOLD_LONG   = 2'd0,
        HOLD_REPEAT = 2'd1,
        HOLD_SAT    = 2'd2
    } hold_state_t;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, restartable stability window,
// accepted level with press/release strobes, and long-press timing.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int LONG_CYC     = LONG_CYC_DEF,
    parameter bit REPEAT_EN    = 1'b0,
    parameter int REPEAT_CYC   = REPEAT_CYC_DEF,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic clk_1KHz,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_level_nxt,
    output logic press,
    output logic key_release,
    output logic long_press
);

    localparam int DEB_W  = cnt_width(DEBOUNCE_CYC);
    localparam int HOLD_W = cnt_width(max_int(LONG_CYC, REPEAT_CYC) + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST     = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST    = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST  = HOLD_W'(REPEAT_CYC - 1);
    localparam logic              RELEASED_RAW = released_raw(ACTIVE_LOW);

    logic sync_1, sync_2, key_sync;

    logic [DEB_W-1:0] deb_cnt, deb_cnt_nxt;
    logic             press_nxt, release_nxt;

    hold_state_t       hold_state, hold_state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic              long_press_nxt;

    // Two-flop synchroniser on the raw pin. The flops hold the pin value
    // itself so they can reset to the released pin level; inverting after
    // the chain is equivalent to inverting before it.
    always_ff @(posedge clk_1KHz or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= RELEASED_RAW;
            sync_2 <= RELEASED_RAW;
        end else begin
            // NOTE: non-blocking so sync_2 takes the previous sync_1 and the
            // chain really is two stages deep.
            sync_1 <= key_raw;
            sync_2 <= sync_1;
        end
    end

    // Active-high pressed level after synchronisation.
    assign key_sync = sync_2 ^ ACTIVE_LOW;

    // Stability window: any sample equal to the accepted level restarts it;
    // DEBOUNCE_CYC consecutive differing samples accept the new level.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // branch can leave one unassigned and infer a latch.
        deb_cnt_nxt   = deb_cnt;
        key_level_nxt = key_level;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
        if (key_sync == key_level) begin
            deb_cnt_nxt = '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_cnt_nxt   = '0;
            key_level_nxt = key_sync;
            press_nxt     = key_sync;
            release_nxt   = ~key_sync;
        end else begin
            deb_cnt_nxt = deb_cnt + DEB_W'(1);
        end
    end

    // Accepted level, stability counter and press/release strobes.
    always_ff @(posedge clk_1KHz or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt     <= '0;
            key_level   <= 1'b0;
            press       <= 1'b0;
            key_release <= 1'b0;
        end else begin
            deb_cnt     <= deb_cnt_nxt;
            key_level   <= key_level_nxt;
            press       <= press_nxt;
            key_release <= release_nxt;
        end
    end

    // Hold timing: counts while the key stays accepted-pressed, fires the
    // first long press LONG_CYC cycles after the press strobe, then either
    // repeats every REPEAT_CYC or parks. A falling level clears everything
    // on the same edge and suppresses any strobe.
    always_comb begin
        hold_state_nxt = hold_state;
        hold_cnt_nxt   = hold_cnt;
        long_press_nxt = 1'b0;
        if (!key_level || !key_level_nxt) begin
            hold_state_nxt = HOLD_LONG;
            hold_cnt_nxt   = '0;
        end else begin
            case (hold_state)
                HOLD_LONG: begin
                    if (hold_cnt == LONG_LAST) begin
                        long_press_nxt = 1'b1;
                        if (REPEAT_EN) begin
                            hold_state_nxt = HOLD_REPEAT;
                            hold_cnt_nxt   = '0;
                        end else begin
                            hold_state_nxt = HOLD_SAT;
                        end
                    end else begin
                        hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                    end
                end
                HOLD_REPEAT: begin
                    if (hold_cnt == REPEAT_LAST) begin
                        long_press_nxt = 1'b1;
                        hold_cnt_nxt   = '0;
                    end else begin
                        hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                    end
                end
                HOLD_SAT: begin
                    hold_cnt_nxt = hold_cnt;
                end
                default: begin
                    hold_state_nxt = HOLD_LONG;
                    hold_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Hold phase, hold counter and long-press strobe registers.
    always_ff @(posedge clk_1KHz or negedge rst_n) begin
        if (!rst_n) begin
            hold_state <= HOLD_LONG;
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            hold_state <= hold_state_nxt;
            hold_cnt   <= hold_cnt_nxt;
            long_press <= long_press_nxt;
        end
    end

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner for the 1 kHz board-control domain.
// The release strobe port is named key_release because 'release' is a
// reserved word in SystemVerilog.
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int N_KEYS       = 4,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int LONG_CYC     = LONG_CYC_DEF,
    parameter bit REPEAT_EN    = 1'b0,
    parameter int REPEAT_CYC   = REPEAT_CYC_DEF,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic              clk_1KHz,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] long_press,
    output logic              any_pressed
);

    logic [N_KEYS-1:0] level_nxt;

    // One fully independent conditioner per key pin.
    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC),
            .REPEAT_EN    (REPEAT_EN),
            .REPEAT_CYC   (REPEAT_CYC),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .clk_1KHz      (clk_1KHz),
            .rst_n         (rst_n),
            .key_raw       (key_raw[i]),
            .key_level     (key_level[i]),
            .key_level_nxt (level_nxt[i]),
            .press         (press[i]),
            .key_release   (key_release[i]),
            .long_press    (long_press[i])
        );
    end

    // any_pressed tracks the next accepted levels so it changes on the
    // same edge as key_level.
    always_ff @(posedge clk_1KHz or negedge rst_n) begin
        if (!rst_n) begin
            any_pressed <= 1'b0;
        end else begin
            any_pressed <= |level_nxt;
        end
    end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
Parameterised N-channel push-button conditioner for the 1 kHz board-control domain.
Each channel synchronises a raw key and debounces it with a restartable stability counter. It then emits a clean level, one-cycle press and release strobes, and a long-press strobe with optional auto-repeat.
It sits between the board key pins and the mode/counter FSMs, and replaces the single-key, level-only filter.

Parameters:
N_KEYS, 4, number of independent key channels (1..16)
DEBOUNCE_CYC, 12, consecutive stable cycles required to accept a new level (>=2)
LONG_CYC, 1000, cycles of accepted-pressed before the first long_press strobe (>DEBOUNCE_CYC)
REPEAT_EN, 0, 1 = repeat long_press every REPEAT_CYC while held; 0 = single strobe
REPEAT_CYC, 200, auto-repeat period in cycles (>=1; ignored when REPEAT_EN=0)
ACTIVE_LOW, 0, 1 = raw pin reads 0 when pressed; all outputs are active-high regardless

Ports:
clk_1KHz  input  1  1 kHz system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
key_raw  input  N_KEYS  raw asynchronous key pins
key_level  output  N_KEYS  debounced level, 1 = pressed
press  output  N_KEYS  one-cycle strobe on accepted press
release  output  N_KEYS  one-cycle strobe on accepted release
long_press  output  N_KEYS  one-cycle strobe on long hold / auto-repeat
any_pressed  output  1  OR of key_level

Behaviour:
- Reset (rst_n=0, async): sync regs are set to the released raw value (ACTIVE_LOW ? 1 : 0). key_level, press, release, long_press, any_pressed = 0. All counters = 0.
- Polarity: k = key_raw ^ ACTIVE_LOW is computed before synchronisation.
- Sync: s1 <= k; s2 <= s1. There are two flops per channel. Only s2 is used downstream.
- Stability counter deb_cnt (width $clog2(DEBOUNCE_CYC)):
  - When s2 == key_level, deb_cnt <= 0. Any glitch restarts the window.
  - When s2 != key_level and deb_cnt < DEBOUNCE_CYC-1, deb_cnt increments.
  - When s2 != key_level and deb_cnt == DEBOUNCE_CYC-1, key_level <= s2 and deb_cnt <= 0. In the same edge, press <= s2 or release <= ~s2.
- Latency: a raw change captured into s1 at edge E0 updates key_level at edge E0+1+DEBOUNCE_CYC, provided the change stays stable throughout.
- Strobes: press, release and long_press are registered and high for exactly one cycle. press and release for one channel are never high together.
- Hold counter hold_cnt (width $clog2(max(LONG_CYC,REPEAT_CYC)+1)):
  - Cleared while key_level=0. Increments while key_level=1.
  - When hold_cnt reaches LONG_CYC-1, long_press is strobed.
  - If REPEAT_EN=1, hold_cnt then reloads so that the next strobe follows every REPEAT_CYC cycles.
  - If REPEAT_EN=0, hold_cnt saturates and no further strobe fires.
  - The first long_press comes exactly LONG_CYC cycles after the press strobe.
- Release during hold: hold_cnt clears on the same edge key_level falls. No long_press is issued in that cycle or later.
- Channels are fully independent. Simultaneous events on different channels all strobe in the same cycle.
- any_pressed is registered, updated on the same edge as key_level (|next key_level).
- Reset mid-operation: all state clears immediately and no strobe is emitted. A key held through reset produces a press strobe DEBOUNCE_CYC+2 edges after rst_n rises.
- Counters never wrap. deb_cnt is bounded by the compare. hold_cnt is bounded by saturate/reload.

Decomposition:
- Shared package key_pkg holds the width helper function, the LONG/REPEAT localparam defaults and the released-level constant derived from ACTIVE_LOW.
- Sub-module key_debounce_ch holds the single-channel sync, deb_cnt, hold_cnt and strobe registers.
- The top level is a generate loop of N_KEYS instances plus the any_pressed OR register.

Test Plan:
1. Reset: hold rst_n=0 with key_raw toggling randomly -> all outputs 0. Release reset with keys idle -> no strobe for 50 cycles.
2. Clean press (N_KEYS=4, DEBOUNCE_CYC=12): key_raw[0] 0→1 captured at edge E0 -> key_level[0]=1 and press[0]=1 at E0+13, press[0] low at E0+14. Release mirrors this with a release strobe.
3. Bounce: key_raw[1] toggles every 5 cycles for 40 cycles, then settles at 1 -> exactly one press[1], 13 edges after the final toggle is captured. No release strobe.
4. Long press (LONG_CYC=100, REPEAT_EN=1, REPEAT_CYC=50): hold key 2 for 300 cycles after press -> long_press[2] at +100, +150, +200, +250. Rerun with REPEAT_EN=0 -> single strobe at +100.
5. Simultaneous/independence: press keys 0 and 3 on the same edge -> both press bits high in the same cycle and any_pressed=1. Release key 3 only -> release[3] strobes, key_level[0] stays 1, any_pressed stays 1.
6. ACTIVE_LOW=1 and mid-operation reset: pin driven 0 (pressed) with rst_n pulsed at press+60 -> outputs clear async and no long_press. press strobe re-issued at rst_n rise + 14 edges.
